pinacolada_uart_rx: RTL and testbench

Parametrised UART receiver for the pinacolada SoC, replacing the fixed 8N1 receiver. Supports configurable baud divisor, data width, parity and stop bits. Adds majority-vote sampling, start-glitch rejection, framing/parity error flags and a small receive FIFO with a valid/ready output handshake. Sits between the asynchronous `rx` pin and the bus-side UART register block.

---
 rtl/pinacolada_uart_pkg.sv | 22 ++
 rtl/pinacolada_sync_fifo.sv | 57 +++++
 rtl/pinacolada_uart_rx.sv | 163 ++++++++++++++++
 tb/tb_pinacolada_uart_rx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinacolada_uart_pkg.sv
// Shared definitions for the pinacolada UART receiver: parity modes and FSM states.
package pinacolada_uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  // Two-of-three vote used for every bit decision.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pinacolada_sync_fifo.sv
// Single-clock FIFO with flop storage; head entry is read straight from storage.
module pinacolada_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so a full FIFO still accepts a write.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage.
  // NOTE: storage is reset here because the head is visible on the outputs and must read as zero after reset; a large RAM would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pinacolada_uart_rx.sv
// Parametrised UART receiver: synchronizer, majority-vote bit sampling,
// start-glitch rejection, parity/framing checks and a receive FIFO.
module pinacolada_uart_rx
  import pinacolada_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         DATA_BITS    = 8,
  parameter logic [1:0] PARITY       = PAR_NONE,
  parameter int         STOP_BITS    = 1,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(M);
  localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  rx_state_e state, state_next;

  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt;
  logic                 s0, s1;
  logic                 maj;
  logic                 at_dec, at_wrap;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_err;
  logic                 par_err;
  logic                 par_bad;
  logic                 push_req;
  logic                 push_q;
  logic [EW-1:0]        wr_data;
  logic [EW-1:0]        head;
  logic                 full, empty;

  assign at_dec  = (cnt == CNT_DEC);
  assign at_wrap = (cnt == CNT_LAST);
  assign maj     = majority3(s0, s1, rx_s);
  assign par_bad = (PARITY == PAR_ODD) ? !(^shreg ^ maj) : (^shreg ^ maj);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and push request at the last stop-bit decision.
  // NOTE: every signal assigned in this block gets a default first, so no path can leave it holding a value and infer a latch.
  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    case (state)
      ST_WAIT_IDLE: if (rx_s) state_next = ST_IDLE;
      ST_IDLE:      if (!rx_s) state_next = ST_START;
      ST_START: begin
        if (at_dec && maj) state_next = ST_IDLE;
        else if (at_wrap)  state_next = ST_DATA;
      end
      ST_DATA: begin
        if (at_wrap && bit_idx == BIT_LAST)
          state_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
      end
      ST_PAR: if (at_wrap) state_next = ST_STOP;
      ST_STOP: begin
        if (at_dec && stop_idx == STOP_LAST) begin
          push_req   = 1'b1;
          state_next = (frame_err || !maj) ? ST_WAIT_IDLE : ST_IDLE;
        end
      end
      default: state_next = ST_WAIT_IDLE;
    endcase
  end

  // Synchronizer, bit timing, sampling and frame assembly.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      push_q    <= 1'b0;
      wr_data   <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;

      if (state == ST_IDLE || state == ST_WAIT_IDLE) cnt <= '0;
      else if (at_wrap)                              cnt <= '0;
      else                                           cnt <= cnt + 1'b1;

      if (cnt == CNT_S0) s0 <= rx_s;
      if (cnt == CNT_S1) s1 <= rx_s;

      case (state)
        ST_IDLE: begin
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          frame_err <= 1'b0;
          par_err   <= 1'b0;
        end
        ST_DATA: begin
          if (at_dec)  shreg   <= {maj, shreg[DATA_BITS-1:1]};
          if (at_wrap) bit_idx <= bit_idx + 1'b1;
        end
        ST_PAR: if (at_dec) par_err <= par_bad;
        ST_STOP: begin
          if (at_dec)  frame_err <= frame_err | ~maj;
          if (at_wrap) stop_idx  <= stop_idx + 1'b1;
        end
        default: ;
      endcase

      push_q <= push_req;
      if (push_req) wr_data <= {shreg, frame_err | ~maj, par_err};
    end
  end

  pinacolada_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (wr_data),
    .pop       (m_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign m_data       = head[EW-1:2];
  assign m_frame_err  = head[1];
  assign m_parity_err = head[0];
  assign m_valid      = !empty;
  assign overrun      = push_q && full && !m_ready;

endmodule

// File: tb/tb_pinacolada_uart_rx.sv
// Self-checking bench: four receiver configurations driven by directed
// frame tables, hand-written corner sequences and a randomized 8E1 run.
module tb_pinacolada_uart_rx;
  import pinacolada_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rx_v  = 4'hF;
  logic [3:0] rdy_v = 4'hF;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] fe_v, pe_v, vld_v, ovr_v;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // unit 0: 8N1, unit 1: 8E1, unit 2: 8N2, unit 3: 7O1 at 5 clocks per bit
  pinacolada_uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .m_data(d0), .m_frame_err(fe_v[0]), .m_parity_err(pe_v[0]),
    .m_valid(vld_v[0]), .m_ready(rdy_v[0]), .overrun(ovr_v[0]));
  pinacolada_uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .m_data(d1), .m_frame_err(fe_v[1]), .m_parity_err(pe_v[1]),
    .m_valid(vld_v[1]), .m_ready(rdy_v[1]), .overrun(ovr_v[1]));
  pinacolada_uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .m_data(d2), .m_frame_err(fe_v[2]), .m_parity_err(pe_v[2]),
    .m_valid(vld_v[2]), .m_ready(rdy_v[2]), .overrun(ovr_v[2]));
  pinacolada_uart_rx #(.CLKS_PER_BIT(5), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .rx(rx_v[3]), .m_data(d3), .m_frame_err(fe_v[3]), .m_parity_err(pe_v[3]),
    .m_valid(vld_v[3]), .m_ready(rdy_v[3]), .overrun(ovr_v[3]));

  // ---------------- per-unit configuration ----------------
  function automatic int u_cpb(input int u);  return (u == 3) ? 5 : 16; endfunction
  function automatic int u_bits(input int u); return (u == 3) ? 7 : 8;  endfunction
  function automatic int u_par(input int u);  return (u == 1) ? 1 : (u == 3) ? 2 : 0; endfunction
  function automatic int u_stop(input int u); return (u == 2) ? 2 : 1;  endfunction
  function automatic int u_len(input int u);
    return 1 + u_bits(u) + ((u_par(u) != 0) ? 1 : 0) + u_stop(u);
  endfunction
  // Cycle (relative to start-bit drive k) in which the last stop bit is decided:
  // 2 synchronizer + 1 detect cycles, then mid-bit decision at M+1.
  function automatic int decide_cyc(input int u, input int k);
    return k + 3 + (u_len(u) - 1) * u_cpb(u) + u_cpb(u) / 2 + 1;
  endfunction

  function automatic logic [8:0] head_data(input int u);
    case (u)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {1'b0, d2};
      default: return {2'b00, d3};
    endcase
  endfunction

  // Reference parity rule: count of ones over data plus parity bit.
  function automatic logic model_pe(input int u, input logic [8:0] d, input logic p);
    int ones;
    ones = 0;
    for (int i = 0; i < u_bits(u); i++) ones += d[i];
    ones += p;
    if (u_par(u) == 0) return 1'b0;
    if (u_par(u) == 1) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  // ---------------- monitor ----------------
  typedef struct {
    int         unit;
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } pop_t;
  typedef struct {
    int unit;
    int cyc;
  } ovr_t;

  pop_t pops[$];
  ovr_t ovrs[$];

  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (vld_v[u] && rdy_v[u]) pops.push_back('{u, head_data(u), fe_v[u], pe_v[u], cyc});
      if (ovr_v[u]) ovrs.push_back('{u, cyc});
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input int idx, input int u, input logic [8:0] d,
                           input logic fe, input logic pe, input int exp_cyc);
    if (idx >= pops.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: entry %0d missing, only %0d popped", name, idx, pops.size());
      return;
    end
    check({name, "_unit"}, pops[idx].unit, u);
    check({name, "_data"}, {23'd0, pops[idx].data}, {23'd0, d});
    check({name, "_fe"}, {31'd0, pops[idx].fe}, {31'd0, fe});
    check({name, "_pe"}, {31'd0, pops[idx].pe}, {31'd0, pe});
    if (exp_cyc >= 0) check({name, "_cycle"}, pops[idx].cyc, exp_cyc);
  endtask

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic drive_bit(input int u, input logic b, input int n);
    rx_v[u] = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int u, input logic [8:0] d, input logic p,
                            input logic [1:0] stops, output int k);
    int cpb;
    cpb = u_cpb(u);
    k = cyc;
    drive_bit(u, 1'b0, cpb);
    for (int i = 0; i < u_bits(u); i++) drive_bit(u, d[i], cpb);
    if (u_par(u) != 0) drive_bit(u, p, cpb);
    for (int i = 0; i < u_stop(u); i++) drive_bit(u, stops[i], cpb);
    rx_v[u] = 1'b1;
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    int         unit;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;
    int         tail_low;
    int         gap;
    logic [8:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  int   ks[NV];

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;
  exp_t exp_q[$];

  initial begin
    int base, obase, k, kk, dummy;
    bit rand_done;

    // {unit, data, parity bit, stop bits (bit0 first), low tail, idle gap, exp data, exp fe, exp pe}
    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11,  0,  0, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h03C, 1'b0, 2'b11,  0, 20, 9'h03C, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h007, 1'b1, 2'b11,  0,  0, 9'h007, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h007, 1'b0, 2'b11,  0, 20, 9'h007, 1'b0, 1'b1};
    vecs[4] = '{1, 9'h0F0, 1'b1, 2'b11,  0, 20, 9'h0F0, 1'b0, 1'b1};
    vecs[5] = '{2, 9'h055, 1'b0, 2'b01, 40, 20, 9'h055, 1'b1, 1'b0};
    vecs[6] = '{2, 9'h081, 1'b0, 2'b11,  0, 20, 9'h081, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h0C3, 1'b0, 2'b10,  0, 20, 9'h0C3, 1'b1, 1'b0};
    vecs[8] = '{3, 9'h02A, 1'b0, 2'b11,  0, 10, 9'h02A, 1'b0, 1'b0};
    vecs[9] = '{3, 9'h07F, 1'b1, 2'b11,  0, 10, 9'h07F, 1'b0, 1'b1};

    // Reset and reset values
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rst_valid_u%0d", u), {31'd0, vld_v[u]}, 32'd0);
      check($sformatf("rst_data_u%0d", u), {23'd0, head_data(u)}, 32'd0);
      check($sformatf("rst_fe_u%0d", u), {31'd0, fe_v[u]}, 32'd0);
      check($sformatf("rst_pe_u%0d", u), {31'd0, pe_v[u]}, 32'd0);
      check($sformatf("rst_ovr_u%0d", u), {31'd0, ovr_v[u]}, 32'd0);
    end
    rst = 1'b0;
    drive_bit(0, 1'b1, 10);

    // Directed table: data, flags and push-to-valid latency
    base = pops.size();
    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].unit, vecs[i].data, vecs[i].par, vecs[i].stops, ks[i]);
      if (vecs[i].tail_low > 0) drive_bit(vecs[i].unit, 1'b0, vecs[i].tail_low);
      drive_bit(vecs[i].unit, 1'b1, vecs[i].gap);
    end
    drive_bit(0, 1'b1, 30);
    check("table_pop_count", pops.size() - base, NV);
    for (int i = 0; i < NV; i++)
      check_pop($sformatf("vec%0d", i), base + i, vecs[i].unit, vecs[i].exp_data,
                vecs[i].exp_fe, vecs[i].exp_pe, decide_cyc(vecs[i].unit, ks[i]) + 2);

    // Start glitch: three low cycles, then a clean frame
    base = pops.size();
    drive_bit(0, 1'b0, 3);
    drive_bit(0, 1'b1, 40);
    check("glitch_no_push", pops.size() - base, 0);
    send_frame(0, 9'h012, 1'b0, 2'b11, k);
    drive_bit(0, 1'b1, 20);
    check("after_glitch_count", pops.size() - base, 1);
    check_pop("after_glitch", base, 0, 9'h012, 1'b0, 1'b0, decide_cyc(0, k) + 2);

    // Overrun: five frames into a four-entry FIFO with no consumer
    rdy_v[0] = 1'b0;
    base  = pops.size();
    obase = ovrs.size();
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 2'b11, k);
    drive_bit(0, 1'b1, 20);
    check("ovr_count", ovrs.size() - obase, 1);
    if (ovrs.size() > obase) check("ovr_cycle", ovrs[obase].cyc, decide_cyc(0, k) + 1);
    check("full_head_valid", {31'd0, vld_v[0]}, 32'd1);
    check("full_head_data", {24'd0, d0}, 32'h01);
    rdy_v[0] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rdy_v[0] = 1'b0;
    check("drained_valid", {31'd0, vld_v[0]}, 32'd0);
    check("drain_count", pops.size() - base, 4);
    for (int i = 0; i < 4; i++) check_pop($sformatf("drain%0d", i), base + i, 0, 9'(i + 1), 1'b0, 1'b0, -1);

    // Push and pop in the same cycle while full
    for (int i = 1; i <= 4; i++) send_frame(0, 9'(8'h10 + i), 1'b0, 2'b11, dummy);
    drive_bit(0, 1'b1, 20);
    base  = pops.size();
    obase = ovrs.size();
    k = cyc;
    fork
      send_frame(0, 9'h015, 1'b0, 2'b11, kk);
      begin
        while (cyc < decide_cyc(0, k) + 1) begin @(posedge clk); #1; end
        rdy_v[0] = 1'b1;
        @(posedge clk); #1;
        rdy_v[0] = 1'b0;
      end
    join
    drive_bit(0, 1'b1, 20);
    check("full_pushpop_no_ovr", ovrs.size() - obase, 0);
    rdy_v[0] = 1'b1;
    drive_bit(0, 1'b1, 10);
    check("full_pushpop_count", pops.size() - base, 5);
    check_pop("pp0", base, 0, 9'h011, 1'b0, 1'b0, decide_cyc(0, k) + 1);
    for (int i = 1; i < 5; i++) check_pop($sformatf("pp%0d", i), base + i, 0, 9'(8'h11 + i), 1'b0, 1'b0, -1);

    // Reset in the middle of a frame with an entry waiting
    rdy_v[0] = 1'b0;
    send_frame(0, 9'h099, 1'b0, 2'b11, dummy);
    drive_bit(0, 1'b1, 20);
    check("pre_rst_valid", {31'd0, vld_v[0]}, 32'd1);
    check("pre_rst_data", {24'd0, d0}, 32'h99);
    base = pops.size();
    k = cyc;
    fork
      send_frame(0, 9'h0FF, 1'b0, 2'b11, kk);
      begin
        while (cyc < k + 3 + 4 * 16) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", {31'd0, vld_v[0]}, 32'd0);
        check("midrst_data", {24'd0, d0}, 32'd0);
        check("midrst_fe", {31'd0, fe_v[0]}, 32'd0);
        check("midrst_pe", {31'd0, pe_v[0]}, 32'd0);
        check("midrst_ovr", {31'd0, ovr_v[0]}, 32'd0);
        rst = 1'b0;
        rdy_v[0] = 1'b1;
      end
    join
    drive_bit(0, 1'b1, 40);
    check("midrst_no_push", pops.size() - base, 0);
    check("midrst_still_empty", {31'd0, vld_v[0]}, 32'd0);
    send_frame(3, 9'h02A, 1'b0, 2'b11, k);
    drive_bit(3, 1'b1, 10);
    check_pop("postrst_7o1", base, 3, 9'h02A, 1'b0, 1'b0, decide_cyc(3, k) + 2);

    // Randomized 8E1 traffic with a randomly stalling consumer
    base = pops.size();
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          logic [8:0] d;
          logic       p, st;
          int         g;
          d  = 9'($urandom_range(0, 255));
          p  = 1'($urandom_range(0, 1));
          st = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
          g  = st ? $urandom_range(0, 20) : $urandom_range(2, 20);
          exp_q.push_back('{d, !st, model_pe(1, d, p)});
          send_frame(1, d, p, {1'b1, st}, dummy);
          drive_bit(1, 1'b1, g);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rdy_v[1] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        rdy_v[1] = 1'b1;
      end
    join
    drive_bit(1, 1'b1, 50);
    check("rand_count", pops.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_pop($sformatf("rand%0d", i), base + i, 1, exp_q[i].data, exp_q[i].fe, exp_q[i].pe, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
